// File: rtl/pe_feeder.sv
// Write side of the PE input FIFO: range-checks both windows, then streams
// fmap/kernel word pairs through a 2-entry skid buffer into the FIFO.
module pe_feeder #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] fmap_base,
    input  logic [ADDR_W-1:0] fmap_limit,
    input  logic [ADDR_W-1:0] kernel_base,
    input  logic [ADDR_W-1:0] kernel_limit,
    output logic              fmap_ren,
    output logic [ADDR_W-1:0] fmap_addr,
    input  logic [31:0]       fmap_rdata,
    output logic              kernel_ren,
    output logic [ADDR_W-1:0] kernel_addr,
    input  logic [31:0]       kernel_rdata,
    input  logic              fifo_full,
    output logic              fifo_wen,
    output logic [63:0]       fifo_wd,
    output logic              busy,
    output logic              done,
    output logic              fmap_2addr_error,
    output logic              kernel_2addr_error
);

    localparam int EW = ADDR_W + LEN_W + 1;

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DRAIN} state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   left;
    logic               inflight;
    logic [1:0][63:0]   skid;
    logic               wp;
    logic               rp;
    logic [1:0]         cnt;

    logic [EW-1:0]      f_end;
    logic [EW-1:0]      k_end;
    logic               f_err;
    logic               k_err;
    logic               len_zero;
    logic               in_check;
    logic [2:0]         occ;
    logic               room;

    // The address regs still hold the bases during CHECK
    assign f_end    = EW'(fmap_addr) + EW'(len_q) - EW'(1);
    assign k_end    = EW'(kernel_addr) + EW'(len_q) - EW'(1);
    assign f_err    = f_end > EW'(fmap_limit);
    assign k_err    = k_end > EW'(kernel_limit);
    assign len_zero = (len_q == '0);
    assign in_check = (state == CHECK);

    assign fmap_2addr_error   = in_check & ~len_zero & f_err;
    assign kernel_2addr_error = in_check & ~len_zero & k_err;

    assign fifo_wen = (cnt != 2'd0) & ~fifo_full;
    assign fifo_wd  = skid[rp];

    // Issue only if the slot freed by this cycle's write keeps occ <= 2
    assign occ        = {1'b0, cnt} + {2'b0, inflight};
    assign room       = (occ - {2'b0, fifo_wen}) < 3'd2;
    assign fmap_ren   = (state == RUN) & (left != '0) & room;
    assign kernel_ren = fmap_ren;

    assign busy = (state != IDLE);
    assign done = (in_check & len_zero)
                | ((state == DRAIN) & (cnt == 2'd0) & ~inflight);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            left        <= '0;
            fmap_addr   <= '0;
            kernel_addr <= '0;
            inflight    <= 1'b0;
            skid        <= '0;
            wp          <= 1'b0;
            rp          <= 1'b0;
            cnt         <= 2'd0;
        end else begin
            inflight <= fmap_ren;
            if (inflight) begin
                skid[wp] <= {kernel_rdata, fmap_rdata};
                wp       <= ~wp;
            end
            if (fifo_wen)
                rp <= ~rp;
            cnt <= cnt + {1'b0, inflight} - {1'b0, fifo_wen};
            if (fmap_ren) begin
                fmap_addr   <= fmap_addr + ADDR_W'(1);
                kernel_addr <= kernel_addr + ADDR_W'(1);
                left        <= left - LEN_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q       <= len;
                        left        <= len;
                        fmap_addr   <= fmap_base;
                        kernel_addr <= kernel_base;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (len_zero || f_err || k_err)
                        state <= IDLE;
                    else
                        state <= RUN;
                end
                RUN: begin
                    if (fmap_ren && left == LEN_W'(1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: SRAM model returns address-tagged data.
module tb_pe_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic [15:0] fmap_base, fmap_limit, kernel_base, kernel_limit;
    logic        fmap_ren, kernel_ren;
    logic [15:0] fmap_addr, kernel_addr;
    logic [31:0] fmap_rdata, kernel_rdata;
    logic        fifo_full;
    logic        fifo_wen;
    logic [63:0] fifo_wd;
    logic        busy, done, fmap_2addr_error, kernel_2addr_error;

    int pass_cnt = 0;
    int total = 0;

    // Job observations
    logic [63:0] words[$];
    int          wen_cyc[$];
    int          ren_cnt, done_cyc, done_cnt;
    int          ferr_cyc, kerr_cyc, ferr_cnt, kerr_cnt, wen_when_full;
    logic [63:0] busy_mask;

    pe_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .fmap_base(fmap_base), .fmap_limit(fmap_limit),
        .kernel_base(kernel_base), .kernel_limit(kernel_limit),
        .fmap_ren(fmap_ren), .fmap_addr(fmap_addr), .fmap_rdata(fmap_rdata),
        .kernel_ren(kernel_ren), .kernel_addr(kernel_addr),
        .kernel_rdata(kernel_rdata), .fifo_full(fifo_full),
        .fifo_wen(fifo_wen), .fifo_wd(fifo_wd), .busy(busy), .done(done),
        .fmap_2addr_error(fmap_2addr_error),
        .kernel_2addr_error(kernel_2addr_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fmap_ren)   fmap_rdata   <= 32'hF000_0000 | {16'h0, fmap_addr};
        if (kernel_ren) kernel_rdata <= 32'hA000_0000 | {16'h0, kernel_addr};
    end

    function automatic logic [63:0] expw(input logic [15:0] fa,
                                         input logic [15:0] ka);
        return {32'hA000_0000 | {16'h0, ka}, 32'hF000_0000 | {16'h0, fa}};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp_v);
        total++;
        if (act !== exp_v)
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        else
            pass_cnt++;
    endtask

    // Start in cycle 0, observe cycles 0..maxc at negedge (+1)
    task automatic run_job(input logic [15:0] l, input logic [15:0] fb,
                           input logic [15:0] kb, input logic [15:0] fl,
                           input logic [15:0] kl, input int full_lo,
                           input int full_hi, input int glitch, input int maxc);
        words.delete();
        wen_cyc.delete();
        ren_cnt = 0; done_cyc = -1; done_cnt = 0;
        ferr_cyc = -1; kerr_cyc = -1; ferr_cnt = 0; kerr_cnt = 0;
        wen_when_full = 0; busy_mask = '0;
        @(negedge clk);
        len = l; fmap_base = fb; kernel_base = kb;
        fmap_limit = fl; kernel_limit = kl; start = 1'b1;
        for (int c = 0; c <= maxc; c++) begin
            if (c > 0) begin
                start = (c == glitch);
                len = (c == glitch) ? 16'd99 : l;
            end
            fifo_full = (c >= full_lo && c <= full_hi);
            #1;
            if (fifo_wen) begin
                words.push_back(fifo_wd);
                wen_cyc.push_back(c);
                if (fifo_full) wen_when_full++;
            end
            if (fmap_ren) ren_cnt++;
            if (fmap_ren !== kernel_ren) wen_when_full++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (fmap_2addr_error) begin ferr_cnt++; ferr_cyc = c; end
            if (kernel_2addr_error) begin kerr_cnt++; kerr_cyc = c; end
            if (c < 64) busy_mask[c] = busy;
            @(negedge clk);
        end
        start = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        chk("reset_outs",
            {fmap_ren, kernel_ren, fifo_wen, busy, done,
             fmap_2addr_error, kernel_2addr_error}, 0);
        chk("reset_wd", fifo_wd, 0);
        chk("reset_addr", {fmap_addr, kernel_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        run_job(16'd4, 16'h10, 16'h80, 16'hFFFF, 16'hFFFF, 99, 99, 3, 20);
        chk("basic_nwords", words.size(), 4);
        chk("basic_nren", ren_cnt, 4);
        for (int i = 0; i < 4 && i < words.size(); i++) begin
            chk("basic_data", words[i], expw(16'h10 + 16'(i), 16'h80 + 16'(i)));
            chk("basic_wcyc", wen_cyc[i], 4 + i);
        end
        chk("basic_done", done_cyc, 8);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_busy", busy_mask[20:0], 21'b000000000000111111110);
    endtask

    task automatic test_backpressure;
        run_job(16'd8, 16'h200, 16'h300, 16'hFFFF, 16'hFFFF, 5, 9, -1, 30);
        chk("bp_nwords", words.size(), 8);
        chk("bp_nren", ren_cnt, 8);
        chk("bp_wen_full", wen_when_full, 0);
        for (int i = 0; i < 8 && i < words.size(); i++)
            chk("bp_data", words[i], expw(16'h200 + 16'(i), 16'h300 + 16'(i)));
        if (wen_cyc.size() >= 2) begin
            chk("bp_first_wcyc", wen_cyc[0], 4);
            chk("bp_second_wcyc", wen_cyc[1], 10);
        end
        chk("bp_done", done_cyc, 17);
    endtask

    task automatic test_fmap_err;
        run_job(16'h20, 16'hFFF0, 16'h0, 16'hFFFF, 16'hFFFF, 99, 99, -1, 10);
        chk("ferr_cyc", ferr_cyc, 1);
        chk("ferr_cnt", ferr_cnt, 1);
        chk("ferr_kerr", kerr_cnt, 0);
        chk("ferr_activity", ren_cnt + words.size() + done_cnt, 0);
        chk("ferr_busy", busy_mask[3:0], 4'b0010);
    endtask

    task automatic test_both_err;
        run_job(16'h10, 16'h100, 16'h200, 16'h105, 16'h20E, 99, 99, -1, 8);
        chk("berr_f", ferr_cyc, 1);
        chk("berr_k", kerr_cyc, 1);
        chk("berr_activity", ren_cnt + words.size() + done_cnt, 0);
        run_job(16'd3, 16'h100, 16'h200, 16'h105, 16'h20E, 99, 99, -1, 12);
        chk("after_err_n", words.size(), 3);
        if (words.size() == 3)
            chk("after_err_last", words[2], expw(16'h102, 16'h202));
        chk("after_err_done", done_cyc, 7);
        chk("after_err_errs", ferr_cnt + kerr_cnt, 0);
    endtask

    task automatic test_len_zero;
        run_job(16'd0, 16'h5, 16'h6, 16'hFFFF, 16'hFFFF, 99, 99, -1, 6);
        chk("len0_done", done_cyc, 1);
        chk("len0_cnt", done_cnt, 1);
        chk("len0_activity", ren_cnt + words.size() + ferr_cnt + kerr_cnt, 0);
    endtask

    task automatic test_back_to_back;
        // start held during the done cycle must be ignored
        run_job(16'd2, 16'h30, 16'h31, 16'hFFFF, 16'hFFFF, 99, 99, 6, 12);
        chk("b2b_done", done_cyc, 6);
        chk("b2b_nwords", words.size(), 2);
        chk("b2b_idle", busy_mask[7], 0);
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        len = 16'd16; fmap_base = 16'h0; kernel_base = 16'h0;
        fmap_limit = 16'hFFFF; kernel_limit = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs",
            {fmap_ren, kernel_ren, fifo_wen, busy, done,
             fmap_2addr_error, kernel_2addr_error}, 0);
        chk("mid_rst_wd", fifo_wd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(16'd2, 16'h40, 16'h50, 16'hFFFF, 16'hFFFF, 99, 99, -1, 12);
        chk("post_rst_n", words.size(), 2);
        for (int i = 0; i < 2 && i < words.size(); i++)
            chk("post_rst_data", words[i], expw(16'h40 + 16'(i), 16'h50 + 16'(i)));
        chk("post_rst_done", done_cyc, 6);
    endtask

    initial begin
        start = 1'b0; len = '0; fifo_full = 1'b0;
        fmap_base = '0; kernel_base = '0;
        fmap_limit = '1; kernel_limit = '1;
        test_reset();
        test_basic();
        test_backpressure();
        test_fmap_err();
        test_both_err();
        test_len_zero();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
